// File: rtl/ss_seq_ctrl.sv
// Save-state sequencer between the host save-state engine and a mapper's
// ss_* port. Walks mapper save-state addresses 0..SS_LAST: a save walk reads
// each register and streams it to the host; a load walk takes host bytes and
// writes each into the mapper, holding ss_we across one falling edge of m2.
module ss_seq_ctrl #(
  parameter int unsigned SS_LAST = 127,
  parameter int unsigned TMO_W   = 16
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       m2,
  input  logic       start_save,
  input  logic       start_load,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam logic [7:0] LAST_ADDR = 8'(SS_LAST);
  // The watchdog fires on the cycle its count would become all-ones.
  localparam logic [TMO_W-1:0] WDT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, SV_SET, SV_CAP, SV_PUSH, LD_GET, LD_ARM, LD_HOLD, FIN
  } state_t;

  state_t           state_reg;
  logic [TMO_W-1:0] wdt_reg;
  // [0],[1] resynchronise m2; [2] is the previous synchronised value.
  logic [2:0]       m2_pipe_reg;
  logic             m2_rise;
  logic             m2_fall;
  logic             last_addr;
  logic             wdt_expire;

  // Bring the asynchronous m2 into the clk domain and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (map_rst) m2_pipe_reg <= 3'b000;
    else         m2_pipe_reg <= {m2_pipe_reg[1:0], m2};
  end

  // Edge pulses and walk-position decodes used by the sequencer.
  always_comb begin
    m2_rise    = m2_pipe_reg[1] & ~m2_pipe_reg[2];
    m2_fall    = ~m2_pipe_reg[1] & m2_pipe_reg[2];
    last_addr  = (ss_addr == LAST_ADDR);
    wdt_expire = (wdt_reg == WDT_LAST);
  end

  // Sequencer: state, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_reg <= IDLE;
      wdt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ss_act    <= 1'b0;
      ss_we     <= 1'b0;
      ss_addr   <= 8'h00;
      ss_wdat   <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state_reg != IDLE) begin
        // Abort drops the walk silently; the host has to restart it.
        state_reg <= IDLE;
        busy      <= 1'b0;
        ss_act    <= 1'b0;
        ss_we     <= 1'b0;
        ss_addr   <= 8'h00;
        out_valid <= 1'b0;
        in_ready  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_save) begin
              state_reg <= SV_SET;
              ss_addr   <= 8'h00;
              ss_act    <= 1'b1;
              busy      <= 1'b1;
            end else if (start_load) begin
              state_reg <= LD_GET;
              ss_addr   <= 8'h00;
              ss_act    <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
          // ss_rdat is combinational from ss_addr; give it a cycle to settle.
          SV_SET: state_reg <= SV_CAP;
          SV_CAP: begin
            out_data  <= ss_rdat;
            out_valid <= 1'b1;
            state_reg <= SV_PUSH;
          end
          SV_PUSH: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_addr) begin
                state_reg <= FIN;
                done      <= 1'b1;
              end else begin
                ss_addr   <= ss_addr + 8'h01;
                state_reg <= SV_SET;
              end
            end
          end
          LD_GET: begin
            if (in_valid && in_ready) begin
              ss_wdat   <= in_data;
              in_ready  <= 1'b0;
              ss_we     <= 1'b1;
              wdt_reg   <= '0;
              state_reg <= LD_ARM;
            end
          end
          // Waiting for a rise first means the fall we hold across comes
          // after addr/data/we have been stable for at least half an m2 cycle.
          LD_ARM: begin
            if (m2_rise) begin
              wdt_reg   <= '0;
              state_reg <= LD_HOLD;
            end else if (wdt_expire) begin
              state_reg <= IDLE;
              err       <= 1'b1;
              ss_we     <= 1'b0;
              ss_act    <= 1'b0;
              busy      <= 1'b0;
              ss_addr   <= 8'h00;
            end else begin
              wdt_reg <= wdt_reg + 1'b1;
            end
          end
          LD_HOLD: begin
            if (m2_fall) begin
              ss_we <= 1'b0;
              if (last_addr) begin
                state_reg <= FIN;
                done      <= 1'b1;
              end else begin
                ss_addr   <= ss_addr + 8'h01;
                in_ready  <= 1'b1;
                state_reg <= LD_GET;
              end
            end else if (wdt_expire) begin
              state_reg <= IDLE;
              err       <= 1'b1;
              ss_we     <= 1'b0;
              ss_act    <= 1'b0;
              busy      <= 1'b0;
              ss_addr   <= 8'h00;
            end else begin
              wdt_reg <= wdt_reg + 1'b1;
            end
          end
          FIN: begin
            ss_act    <= 1'b0;
            busy      <= 1'b0;
            ss_addr   <= 8'h00;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
